// File: rtl/inverse_cdf_fold_pipe.sv
// rtl/inverse_cdf_fold_pipe.sv - multi-lane elastic fold/clamp/classify front end for the inverse-normal-CDF datapath
// Stage 0 folds u onto p = min(u, 1-u); the remaining LAT-1 stages are plain registers for retiming.
module inverse_cdf_fold_pipe #(
  parameter int WIDTH = 32,
  parameter int QFRAC = 16,
  parameter int LANES = 4,
  parameter int LAT   = 2,
  parameter int P_LOW = 1589,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [LANES*WIDTH-1:0] u,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [LANES*WIDTH-1:0] p,
  output logic [LANES-1:0]       negate,
  output logic [LANES-1:0]       tail,
  output logic [LANES-1:0]       clamped,
  input  logic                   clr_cnt,
  output logic [CNTW-1:0]        clamp_cnt
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << QFRAC;
  localparam logic [WIDTH-1:0] HALF    = ONE >> 1;
  localparam logic [WIDTH-1:0] PLOW    = WIDTH'(P_LOW);
  localparam logic [CNTW:0]    CNT_MAX = {1'b0, {CNTW{1'b1}}};

  logic [LAT-1:0]         r_v;
  logic [LANES*WIDTH-1:0] r_p     [LAT];
  logic [LANES-1:0]       r_neg   [LAT];
  logic [LANES-1:0]       r_tail  [LAT];
  logic [LANES-1:0]       r_clamp [LAT];
  logic [CNTW-1:0]        r_cnt;

  logic [LANES*WIDTH-1:0] w_p;
  logic [LANES-1:0]       w_neg;
  logic [LANES-1:0]       w_tail;
  logic [LANES-1:0]       w_clamp;
  logic [CNTW:0]          w_pop;
  logic [CNTW:0]          w_sum;
  logic [LAT-1:0]         w_en;
  logic                   w_acc;

  always_comb begin : c_fold
    logic [WIDTH-1:0] v_u;
    logic [WIDTH-1:0] v_p;
    w_p     = '0;
    w_neg   = '0;
    w_tail  = '0;
    w_clamp = '0;
    w_pop   = '0;
    v_u     = '0;
    v_p     = '0;
    for (int i = 0; i < LANES; i++) begin
      v_u = u[i*WIDTH +: WIDTH];
      if (v_u >= ONE) begin
        v_u        = ONE - WIDTH'(1);
        w_clamp[i] = 1'b1;
      end
      if (v_u == '0) begin
        v_p        = WIDTH'(1);
        w_clamp[i] = 1'b1;
      end else if (v_u <= HALF) begin
        v_p = v_u;
      end else begin
        v_p      = ONE - v_u;
        w_neg[i] = 1'b1;
      end
      w_p[i*WIDTH +: WIDTH] = v_p;
      w_tail[i]             = (v_p < PLOW);
      w_pop                 = w_pop + (CNTW+1)'(w_clamp[i]);
    end
  end

  // Stage k may load when it, or any stage downstream of it, has a hole, or the sink drains.
  always_comb begin
    w_en = '0;
    for (int k = 0; k < LAT; k++) begin
      w_en[k] = ready_in;
      for (int j = k; j < LAT; j++) begin
        if (!r_v[j]) w_en[k] = 1'b1;
      end
    end
  end

  assign w_acc = valid_in && w_en[0];
  assign w_sum = {1'b0, r_cnt} + w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= '0;
      r_cnt <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_p[k]     <= '0;
        r_neg[k]   <= '0;
        r_tail[k]  <= '0;
        r_clamp[k] <= '0;
      end
    end else begin
      if (w_en[0]) begin
        r_v[0] <= valid_in;
        if (valid_in) begin
          r_p[0]     <= w_p;
          r_neg[0]   <= w_neg;
          r_tail[0]  <= w_tail;
          r_clamp[0] <= w_clamp;
        end
      end
      for (int k = 1; k < LAT; k++) begin
        if (w_en[k]) begin
          r_v[k] <= r_v[k-1];
          if (r_v[k-1]) begin
            r_p[k]     <= r_p[k-1];
            r_neg[k]   <= r_neg[k-1];
            r_tail[k]  <= r_tail[k-1];
            r_clamp[k] <= r_clamp[k-1];
          end
        end
      end
      if (clr_cnt) begin
        r_cnt <= w_acc ? CNTW'(w_pop) : '0;
      end else if (w_acc) begin
        r_cnt <= (w_sum > CNT_MAX) ? CNT_MAX[CNTW-1:0] : w_sum[CNTW-1:0];
      end
    end
  end

  assign ready_out = w_en[0];
  assign valid_out = r_v[LAT-1];
  assign p         = r_p[LAT-1];
  assign negate    = r_neg[LAT-1];
  assign tail      = r_tail[LAT-1];
  assign clamped   = r_clamp[LAT-1];
  assign clamp_cnt = r_cnt;

endmodule

// File: tb/tb_inverse_cdf_fold_pipe.sv
// tb/tb_inverse_cdf_fold_pipe.sv - directed self-checking bench for inverse_cdf_fold_pipe
module tb_inverse_cdf_fold_pipe;
  localparam int W = 32;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_in;
  logic           ready_out;
  logic [L*W-1:0] u;
  logic           valid_out;
  logic           ready_in;
  logic [L*W-1:0] p;
  logic [L-1:0]   negate;
  logic [L-1:0]   tail;
  logic [L-1:0]   clamped;
  logic           clr_cnt;
  logic [15:0]    clamp_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inverse_cdf_fold_pipe #(
    .WIDTH(32), .QFRAC(16), .LANES(4), .LAT(2), .P_LOW(1589), .CNTW(16)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .u(u),
    .valid_out(valid_out), .ready_in(ready_in), .p(p), .negate(negate),
    .tail(tail), .clamped(clamped), .clr_cnt(clr_cnt), .clamp_cnt(clamp_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] beat(input int j);
    logic [31:0] b;
    b = 32'(j + 1) << 8;
    return pack4(b, b + 32'd1, b + 32'd2, b + 32'd3);
  endfunction

  // One isolated beat; output checked after LAT edges.
  task automatic send_one(input string tag, input logic [127:0] uv);
    u        = uv;
    valid_in = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk({tag, "_not_yet"}, valid_out, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, valid_out, 1'b1);
  endtask

  initial begin
    logic [127:0] q[$];
    int sent;
    int got;

    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    clr_cnt  = 1'b0;
    u        = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_p", p, '0);
    chk("rst_negate", negate, '0);
    chk("rst_tail", tail, '0);
    chk("rst_clamped", clamped, '0);
    chk("rst_cnt", clamp_cnt, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready_out, 1'b1);

    send_one("t1", pack4(32'h8000, 32'hC000, 32'h0001, 32'h7FFF));
    chk("t1_p", p, pack4(32'h8000, 32'h4000, 32'h0001, 32'h7FFF));
    chk("t1_negate", negate, 4'b0010);
    chk("t1_tail", tail, 4'b0100);
    chk("t1_clamped", clamped, 4'b0000);
    chk("t1_cnt", clamp_cnt, 16'd0);

    send_one("t2", pack4(32'h0, 32'h10000, 32'hFFFF, 32'h0400));
    chk("t2_p", p, pack4(32'h1, 32'h1, 32'h1, 32'h0400));
    chk("t2_clamped", clamped, 4'b0011);
    chk("t2_negate", negate, 4'b0110);
    chk("t2_tail", tail, 4'b1111);
    chk("t2_cnt", clamp_cnt, 16'd2);

    send_one("t3", pack4(32'd1588, 32'd1589, 32'd63947, 32'h8000));
    chk("t3_p", p, pack4(32'd1588, 32'd1589, 32'd1589, 32'h8000));
    chk("t3_tail", tail, 4'b0001);
    chk("t3_negate", negate, 4'b0100);
    chk("t3_clamped", clamped, 4'b0000);

    u = pack4(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("idle_valid_out", valid_out, 1'b0);
    chk("idle_cnt", clamp_cnt, 16'd2);

    sent = 0;
    got  = 0;
    for (int c = 0; c < 80 && got < 20; c++) begin
      ready_in = !(c >= 5 && c <= 9);
      valid_in = (sent < 20);
      u        = beat(sent);
      #1;
      chk("t4_ready_out", ready_out, (q.size() < 2) || ready_in);
      if (valid_out) begin
        if (q.size() == 0) chk("t4_spurious", valid_out, 1'b0);
        else               chk("t4_p_order", p, q[0]);
      end
      if (valid_out && ready_in && q.size() > 0) begin
        void'(q.pop_front());
        got++;
      end
      if (valid_in && ready_out) begin
        q.push_back(beat(sent));
        sent++;
      end
      @(negedge clk);
    end
    chk("t4_got", got, 20);
    chk("t4_sent", sent, 20);
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);

    valid_in = 1'b1;
    u        = beat(30);
    @(negedge clk);
    u = beat(31);
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_valid_out", valid_out, 1'b0);
    chk("t5_p", p, '0);
    chk("t5_cnt", clamp_cnt, 16'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_no_emit", valid_out, 1'b0);
    end

    u        = '0;
    valid_in = 1'b1;
    ready_in = 1'b1;
    repeat (16390) @(negedge clk);
    chk("t6_sat", clamp_cnt, 16'hFFFF);
    chk("t6_clamped", clamped, 4'b1111);
    chk("t6_p", p, pack4(32'h1, 32'h1, 32'h1, 32'h1));
    clr_cnt = 1'b1;
    u       = pack4(32'h0, 32'h4000, 32'h20000, 32'h0100);
    @(negedge clk);
    clr_cnt  = 1'b0;
    valid_in = 1'b0;
    chk("t6_clr_accept", clamp_cnt, 16'd2);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("t6_clr_only", clamp_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
